ps2_cmd_sequencer: RTL and testbench

Parametrised PS/2 host command sequencer. On a start pulse it issues a programmable list of N_CMDS command bytes to the device through a byte-level PS/2 transmitter. For each command it checks the device ACK (0xFA), collects a per-command number of response bytes, and handles resend requests and timeouts with bounded retries. It sits between the mouse/keyboard top level and the PS/2 send/read byte engines, and replaces the fixed three-command, ACK-blind initialisation loop.

---
 rtl/ps2_cmd_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_ps2_cmd_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_cmd_sequencer.sv
// rtl/ps2_cmd_sequencer.sv - PS/2 host command sequencer with ACK checking, responses and bounded retries
module ps2_cmd_sequencer #(
    parameter int N_CMDS         = 3,
    parameter int CLK_HZ         = 50_000_000,
    parameter int ACK_TIMEOUT_MS = 25,
    parameter int GAP_US         = 1000,
    parameter int MAX_RETRY      = 2
) (
    input  logic                qzt_clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [8*N_CMDS-1:0] cmd_list,
    input  logic [2*N_CMDS-1:0] rsp_len,
    output logic [7:0]          tx_data,
    output logic                tx_start,
    input  logic                tx_done,
    input  logic                tx_err,
    input  logic                rx_valid,
    input  logic [7:0]          rx_data,
    output logic                rsp_valid,
    output logic [7:0]          rsp_data,
    output logic [3:0]          rsp_idx,
    output logic                busy,
    output logic                done,
    output logic                fail,
    output logic [1:0]          fail_code
);
    localparam int TO_CYC  = CLK_HZ / 1000 * ACK_TIMEOUT_MS;
    localparam int GAP_CYC = CLK_HZ / 1_000_000 * GAP_US;
    localparam int TW      = (TO_CYC < 1) ? 1 : $clog2(TO_CYC + 1);
    localparam int GW      = (GAP_CYC < 1) ? 1 : $clog2(GAP_CYC + 1);
    localparam int RW      = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {IDLE, SEND, WAIT_TX, WAIT_ACK, WAIT_RSP, GAP} state_t;

    state_t        state, state_n;
    logic [3:0]    idx, idx_n;
    logic [RW-1:0] retry, retry_n;
    logic [1:0]    rcnt, rcnt_n;
    logic [TW-1:0] tmr, tmr_n;
    logic [GW-1:0] gcnt, gcnt_n;
    logic [7:0]    tx_data_n, rsp_data_n;
    logic [3:0]    rsp_idx_n;
    logic [1:0]    fail_code_n;
    logic          tx_start_n, rsp_valid_n, busy_n, done_n, fail_n;
    logic          retry_ev, retry_txerr;
    logic [7:0]    cur_cmd;
    logic [1:0]    cur_len;

    always_comb begin
        cur_cmd = 8'h00;
        cur_len = 2'd0;
        for (int i = 0; i < N_CMDS; i++) begin
            if (idx == 4'(i)) begin
                cur_cmd = cmd_list[8*i +: 8];
                cur_len = rsp_len[2*i +: 2];
            end
        end
    end

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        retry_n     = retry;
        rcnt_n      = rcnt;
        tmr_n       = tmr;
        gcnt_n      = gcnt;
        tx_data_n   = tx_data;
        tx_start_n  = 1'b0;
        rsp_valid_n = 1'b0;
        rsp_data_n  = rsp_data;
        rsp_idx_n   = rsp_idx;
        busy_n      = busy;
        done_n      = 1'b0;
        fail_n      = 1'b0;
        fail_code_n = fail_code;
        retry_ev    = 1'b0;
        retry_txerr = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    idx_n       = 4'd0;
                    retry_n     = '0;
                    fail_code_n = 2'd0;
                    busy_n      = 1'b1;
                    state_n     = SEND;
                end
            end
            SEND: begin
                tx_data_n  = cur_cmd;
                tx_start_n = 1'b1;
                state_n    = WAIT_TX;
            end
            WAIT_TX: begin
                if (tx_err) begin
                    retry_ev    = 1'b1;
                    retry_txerr = 1'b1;
                end else if (tx_done) begin
                    tmr_n   = TW'(TO_CYC);
                    state_n = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                // A received byte takes priority over a timer that expires in the same cycle
                if (rx_valid) begin
                    if (rx_data == 8'hFA) begin
                        rcnt_n  = cur_len;
                        tmr_n   = TW'(TO_CYC);
                        gcnt_n  = GW'(GAP_CYC);
                        state_n = (cur_len != 2'd0) ? WAIT_RSP : GAP;
                    end else if (rx_data == 8'hFE) begin
                        retry_ev = 1'b1;
                    end else if (rx_data == 8'hFC) begin
                        fail_n      = 1'b1;
                        fail_code_n = 2'd1;
                        busy_n      = 1'b0;
                        state_n     = IDLE;
                    end else if (tmr != '0) begin
                        tmr_n = tmr - TW'(1);
                    end
                end else if (tmr == '0) begin
                    retry_ev = 1'b1;
                end else begin
                    tmr_n = tmr - TW'(1);
                end
            end
            WAIT_RSP: begin
                if (rx_valid) begin
                    rsp_valid_n = 1'b1;
                    rsp_data_n  = rx_data;
                    rsp_idx_n   = idx;
                    rcnt_n      = rcnt - 2'd1;
                    tmr_n       = TW'(TO_CYC);
                    if (rcnt == 2'd1) begin
                        gcnt_n  = GW'(GAP_CYC);
                        state_n = GAP;
                    end
                end else if (tmr == '0) begin
                    retry_ev = 1'b1;
                end else begin
                    tmr_n = tmr - TW'(1);
                end
            end
            GAP: begin
                if (gcnt != '0) begin
                    gcnt_n = gcnt - GW'(1);
                end else if (idx == 4'(N_CMDS - 1)) begin
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else begin
                    idx_n   = idx + 4'd1;
                    retry_n = '0;
                    state_n = SEND;
                end
            end
            default: state_n = IDLE;
        endcase

        // Resend the same command until the retry budget is spent, then abort
        if (retry_ev) begin
            if (int'(retry) < MAX_RETRY) begin
                retry_n = retry + RW'(1);
                rcnt_n  = 2'd0;
                state_n = SEND;
            end else begin
                fail_n      = 1'b1;
                fail_code_n = retry_txerr ? 2'd3 : 2'd2;
                busy_n      = 1'b0;
                state_n     = IDLE;
            end
        end
    end

    always_ff @(posedge qzt_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= 4'd0;
            retry     <= '0;
            rcnt      <= 2'd0;
            tmr       <= '0;
            gcnt      <= '0;
            tx_data   <= 8'h00;
            tx_start  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'h00;
            rsp_idx   <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
            fail_code <= 2'd0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            retry     <= retry_n;
            rcnt      <= rcnt_n;
            tmr       <= tmr_n;
            gcnt      <= gcnt_n;
            tx_data   <= tx_data_n;
            tx_start  <= tx_start_n;
            rsp_valid <= rsp_valid_n;
            rsp_data  <= rsp_data_n;
            rsp_idx   <= rsp_idx_n;
            busy      <= busy_n;
            done      <= done_n;
            fail      <= fail_n;
            fail_code <= fail_code_n;
        end
    end
endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// tb/tb_ps2_cmd_sequencer.sv - scoreboard bench for ps2_cmd_sequencer with a scripted PS/2 device model
module tb_ps2_cmd_sequencer;
    localparam int N_CMDS  = 3;
    localparam int CLK_HZ  = 1_000_000;
    localparam int TO_MS   = 1;
    localparam int GAP_US  = 20;
    localparam int MAXR    = 2;
    localparam int TO_CYC  = 1000;
    localparam int PERIOD  = 10;

    logic                qzt_clk = 1'b0;
    logic                rst_n, start, tx_done, tx_err, rx_valid;
    logic [8*N_CMDS-1:0] cmd_list;
    logic [2*N_CMDS-1:0] rsp_len;
    logic [7:0]          rx_data, tx_data, rsp_data;
    logic                tx_start, rsp_valid, busy, done, fail;
    logic [3:0]          rsp_idx;
    logic [1:0]          fail_code;

    ps2_cmd_sequencer #(
        .N_CMDS(N_CMDS), .CLK_HZ(CLK_HZ), .ACK_TIMEOUT_MS(TO_MS),
        .GAP_US(GAP_US), .MAX_RETRY(MAXR)
    ) dut (
        .qzt_clk(qzt_clk), .rst_n(rst_n), .start(start), .cmd_list(cmd_list),
        .rsp_len(rsp_len), .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done),
        .tx_err(tx_err), .rx_valid(rx_valid), .rx_data(rx_data), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_idx(rsp_idx), .busy(busy), .done(done), .fail(fail),
        .fail_code(fail_code)
    );

    always #(PERIOD/2) qzt_clk = ~qzt_clk;

    typedef struct {
        bit          err;
        int          n;
        logic [31:0] b;
        int          gap;
    } plan_t;

    plan_t       plans[$];
    logic [7:0]  sent_q[$];
    time         sent_t[$];
    logic [11:0] exp_q[$];
    int          n_tests = 0, n_fail = 0, done_cnt = 0, fail_cnt = 0;

    function automatic plan_t mk(bit err, int n, logic [31:0] b, int gap);
        plan_t p;
        p.err = err; p.n = n; p.b = b; p.gap = gap;
        return p;
    endfunction

    function automatic logic [39:0] packed_sent();
        logic [39:0] r;
        r = '0;
        r[39:32] = 8'(sent_q.size());
        for (int i = 0; i < sent_q.size() && i < 4; i++) r[31:0] = {r[23:0], sent_q[i]};
        return r;
    endfunction

    task automatic tick();
        @(posedge qzt_clk);
        #1;
    endtask

    // Device: answers each tx_start with the next scripted plan (silent when none is queued)
    initial begin
        plan_t p;
        tx_done = 0; tx_err = 0; rx_valid = 0; rx_data = 8'h00;
        forever begin
            tick();
            if (tx_start && rst_n) begin
                sent_q.push_back(tx_data);
                sent_t.push_back($time);
                p = (plans.size() > 0) ? plans.pop_front() : mk(0, 0, 32'h0, 2);
                repeat (3) tick();
                tx_done = 1'b1; tx_err = p.err;
                tick();
                tx_done = 1'b0; tx_err = 1'b0;
                for (int k = 0; k < p.n; k++) begin
                    repeat (p.gap) tick();
                    rx_data = p.b[8*k +: 8]; rx_valid = 1'b1;
                    tick();
                    rx_valid = 1'b0;
                end
            end
        end
    end

    // Scoreboard: every forwarded response byte must match the head of exp_q
    always @(negedge qzt_clk) begin
        if (rst_n) begin
            if (rsp_valid) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rsp_unexpected got idx=%0d data=%02h expected none", rsp_idx, rsp_data);
                end else if ({rsp_idx, rsp_data} !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL rsp_data got %03h expected %03h", {rsp_idx, rsp_data}, exp_q[0]);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
            end
            if (done) done_cnt++;
            if (fail) fail_cnt++;
            if (done || fail) begin
                n_tests++;
                if (busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL busy_at_end got %b expected 0", busy);
                end
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        int base, k;
        base = done_cnt + fail_cnt;
        k = 0;
        while (done_cnt + fail_cnt == base && k < budget) begin tick(); k++; end
        n_tests++;
        if (done_cnt + fail_cnt == base) begin
            n_fail++;
            $display("FAIL seq_end_timeout got no done/fail in %0d cycles expected one", budget);
        end
        repeat (5) tick();
    endtask

    task automatic setup(input logic [23:0] cmds, input logic [5:0] lens);
        plans.delete(); sent_q.delete(); sent_t.delete(); exp_q.delete();
        cmd_list = cmds; rsp_len = lens;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0;
        setup(24'hF4EAF2, 6'b00_00_01);
        repeat (3) tick();
        n_tests++;
        if ({tx_data, tx_start, rsp_valid, rsp_data, rsp_idx, busy, done, fail, fail_code} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got %h expected 0",
                     {tx_data, tx_start, rsp_valid, rsp_data, rsp_idx, busy, done, fail, fail_code});
        end
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_basic();
        int d0, f0;
        setup(24'hF4EAF2, 6'b00_00_01);
        plans.push_back(mk(0, 2, 32'h0000_00FA, 2));
        plans.push_back(mk(0, 1, 32'h0000_00FA, 2));
        plans.push_back(mk(0, 1, 32'h0000_00FA, 2));
        exp_q.push_back({4'd0, 8'h00});
        d0 = done_cnt; f0 = fail_cnt;
        pulse_start();
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_start got %b expected 1", busy); end
        wait_end(5000);
        n_tests++;
        if (packed_sent() !== 40'h03_00F2EAF4) begin
            n_fail++; $display("FAIL basic_sent got %h expected 0300f2eaf4", packed_sent());
        end
        n_tests++;
        if (done_cnt - d0 != 1 || fail_cnt != f0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL basic_end got done=%0d fail=%0d pend=%0d expected 1 0 0",
                     done_cnt - d0, fail_cnt - f0, exp_q.size());
        end
    endtask

    task automatic test_resend();
        int d0;
        setup(24'hF4EAF2, 6'b00_00_01);
        plans.push_back(mk(0, 2, 32'h0000_00FA, 2));
        plans.push_back(mk(0, 1, 32'h0000_00FE, 2));
        plans.push_back(mk(0, 1, 32'h0000_00FA, 2));
        plans.push_back(mk(0, 1, 32'h0000_00FA, 2));
        exp_q.push_back({4'd0, 8'h00});
        d0 = done_cnt;
        pulse_start();
        wait_end(5000);
        n_tests++;
        if (packed_sent() !== 40'h04_F2EAEAF4 || done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL resend got sent=%h done=%0d expected 04f2eaeaf4 1", packed_sent(), done_cnt - d0);
        end
    endtask

    task automatic test_timeout();
        int f0;
        setup(24'hF4EAF2, 6'b00_00_01);
        f0 = fail_cnt;
        pulse_start();
        wait_end(5000);
        n_tests++;
        if (packed_sent() !== 40'h03_00F2F2F2 || fail_cnt - f0 != 1 || fail_code !== 2'd2) begin
            n_fail++;
            $display("FAIL timeout_fail got sent=%h fail=%0d code=%0d expected 0300f2f2f2 1 2",
                     packed_sent(), fail_cnt - f0, fail_code);
        end
        n_tests++;
        if (sent_t.size() != 3 || sent_t[1] - sent_t[0] < TO_CYC * PERIOD ||
            sent_t[2] - sent_t[1] < TO_CYC * PERIOD) begin
            n_fail++;
            $display("FAIL timeout_spacing got %0d sends expected 3 sends at least %0d apart",
                     sent_t.size(), TO_CYC * PERIOD);
        end
    endtask

    task automatic test_device_error();
        setup(24'hF4EAF2, 6'b00_00_01);
        plans.push_back(mk(0, 2, 32'h0000_00FA, 2));
        plans.push_back(mk(0, 1, 32'h0000_00FC, 2));
        exp_q.push_back({4'd0, 8'h00});
        pulse_start();
        wait_end(5000);
        repeat (50) tick();
        n_tests++;
        if (packed_sent() !== 40'h02_0000F2EA || fail_code !== 2'd1) begin
            n_fail++;
            $display("FAIL dev_error got sent=%h code=%0d expected 020000f2ea 1", packed_sent(), fail_code);
        end
    endtask

    task automatic test_tx_err();
        setup(24'hF4EAF2, 6'b00_00_01);
        for (int i = 0; i < 3; i++) plans.push_back(mk(1, 0, 32'h0, 2));
        pulse_start();
        n_tests++;
        if (fail_code !== 2'd0) begin n_fail++; $display("FAIL code_clear got %0d expected 0", fail_code); end
        wait_end(5000);
        n_tests++;
        if (packed_sent() !== 40'h03_00F2F2F2 || fail_code !== 2'd3) begin
            n_fail++;
            $display("FAIL tx_err got sent=%h code=%0d expected 0300f2f2f2 3", packed_sent(), fail_code);
        end
    endtask

    task automatic test_start_and_reset();
        int d0, f0, k;
        setup(24'hF4EAF2, 6'b00_00_10);
        plans.push_back(mk(0, 2, 32'h0000_11FA, 40));
        exp_q.push_back({4'd0, 8'h11});
        d0 = done_cnt; f0 = fail_cnt;
        pulse_start();
        k = 0;
        while (sent_q.size() == 0 && k < 100) begin tick(); k++; end
        repeat (10) tick();
        pulse_start();
        k = 0;
        while (exp_q.size() != 0 && k < 500) begin tick(); k++; end
        n_tests++;
        if (exp_q.size() != 0 || packed_sent() !== 40'h01_000000F2 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL start_ignored got pend=%0d sent=%h busy=%b expected 0 01000000f2 1",
                     exp_q.size(), packed_sent(), busy);
        end
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({tx_data, tx_start, rsp_valid, rsp_data, rsp_idx, busy, done, fail, fail_code} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs got %h expected 0",
                     {tx_data, tx_start, rsp_valid, rsp_data, rsp_idx, busy, done, fail, fail_code});
        end
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        n_tests++;
        if (done_cnt != d0 || fail_cnt != f0) begin
            n_fail++;
            $display("FAIL reset_no_pulse got done=%0d fail=%0d expected 0 0", done_cnt - d0, fail_cnt - f0);
        end
        setup(24'hF4EAF2, 6'b00_00_01);
        plans.push_back(mk(0, 2, 32'h0000_00FA, 2));
        plans.push_back(mk(0, 1, 32'h0000_00FA, 2));
        plans.push_back(mk(0, 1, 32'h0000_00FA, 2));
        exp_q.push_back({4'd0, 8'h00});
        pulse_start();
        wait_end(5000);
        n_tests++;
        if (packed_sent() !== 40'h03_00F2EAF4 || done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL restart got sent=%h done=%0d expected 0300f2eaf4 1", packed_sent(), done_cnt - d0);
        end
    endtask

    task automatic test_stray_byte();
        int d0;
        setup(24'hF4EAFF, 6'b00_00_10);
        plans.push_back(mk(0, 4, 32'h00AA_FA55, 3));
        plans.push_back(mk(0, 1, 32'h0000_00FA, 2));
        plans.push_back(mk(0, 1, 32'h0000_00FA, 2));
        exp_q.push_back({4'd0, 8'hAA});
        exp_q.push_back({4'd0, 8'h00});
        d0 = done_cnt;
        pulse_start();
        wait_end(5000);
        n_tests++;
        if (packed_sent() !== 40'h03_00FFEAF4 || done_cnt - d0 != 1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL stray got sent=%h done=%0d pend=%0d expected 0300ffeaf4 1 0",
                     packed_sent(), done_cnt - d0, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_resend();
        test_timeout();
        test_device_error();
        test_tx_err();
        test_start_and_reset();
        test_stray_byte();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
